// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sharing of the single data-memory port between
// the core LSU (m0) and the DMA/debug master (m1). One access is in flight at
// a time; the arbiter waits out the fixed memory read latency and then returns
// a one-cycle completion pulse with read data to the winner only.
module data_mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Latency counter is 3 bits wide, enough for the 1..7 legal range.
    localparam logic [2:0] LAT = 3'(MEM_LAT);

    logic [1:0]  state_q, state_d;
    logic        rr_q, rr_d;
    logic        win_q, win_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        pick;
    logic        issue;
    logic        resp;

    // Winner selection: a lone requester wins, a tie is broken by rr_q.
    always_comb begin
        pick = m1_req_i;
        if (m0_req_i && m1_req_i) begin
            pick = rr_q;
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP sequence.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                // Requester inputs are only looked at here; the access is
                // captured so later changes on the request side are ignored.
                if (m0_req_i || m1_req_i) begin
                    win_d   = pick;
                    we_d    = pick ? m1_we_i    : m0_we_i;
                    be_d    = pick ? m1_be_i    : m0_be_i;
                    addr_d  = pick ? m1_addr_i  : m0_addr_i;
                    wdata_d = pick ? m1_wdata_i : m0_wdata_i;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = 3'd1;
                rr_d    = ~win_q;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == LAT) begin
                    rdata_d = we_q ? 32'd0 : mem_rdata_i;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-access registers; reset drops any in-flight access.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 3'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign issue = (state_q == ST_ISSUE);
    assign resp  = (state_q == ST_RESP);

    // Address, byte enables and write data simply hold after the strobe.
    assign mem_req_o   = issue;
    assign mem_we_o    = issue & we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign m0_gnt_o    = issue & ~win_q;
    assign m1_gnt_o    = issue &  win_q;
    assign m0_rvalid_o = resp  & ~win_q;
    assign m1_rvalid_o = resp  &  win_q;
    // The non-winner never sees another requester's data.
    assign m0_rdata_o  = m0_rvalid_o ? rdata_q : 32'd0;
    assign m1_rdata_o  = m1_rvalid_o ? rdata_q : 32'd0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: one instance with MEM_LAT=1 (a_*) and
// one with MEM_LAT=3 (b_*) share the requester inputs; each scenario checks
// the instance it targets.
module tb_data_mem_arbiter;

    logic        clk;
    logic        arstn;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] mem_rdata, mem_rdata_drv;
    logic        use_model;

    logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_req, a_mem_we;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_be;
    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_req, b_mem_we;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_be;

    int n_tests;
    int n_fail;

    // Memory model for the round-robin scenario: data encodes the address.
    assign mem_rdata = use_model ? (32'hA000_0000 | a_mem_addr) : mem_rdata_drv;

    data_mem_arbiter #(.MEM_LAT(1)) dut_a (
        .clk_i(clk), .arstn_i(arstn),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid),
        .m0_rdata_o(a_m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid),
        .m1_rdata_o(a_m1_rdata),
        .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_be_o(a_mem_be),
        .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_rdata_i(mem_rdata)
    );

    data_mem_arbiter #(.MEM_LAT(3)) dut_b (
        .clk_i(clk), .arstn_i(arstn),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid),
        .m0_rdata_o(b_m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid),
        .m1_rdata_o(b_m1_rdata),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be),
        .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_be = 4'h0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_be = 4'h0; m1_addr = 0; m1_wdata = 0;
        mem_rdata_drv = 32'h0; use_model = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        arstn = 0;
        step();
        step();
        arstn = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        arstn = 0;
        m0_req = 1; m1_req = 1; m0_addr = 32'h44; mem_rdata_drv = 32'hFFFF_FFFF;
        step();
        step();
        n_tests++; if ({a_mem_req, a_mem_we, a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid} !== 6'b0) begin n_fail++; $display("FAIL reset_ctl_a got %b exp 000000", {a_mem_req, a_mem_we, a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid}); end
        n_tests++; if ({a_mem_addr, a_mem_wdata, a_m0_rdata, a_m1_rdata} !== 128'd0) begin n_fail++; $display("FAIL reset_data_a addr=%h wdata=%h r0=%h r1=%h exp 0", a_mem_addr, a_mem_wdata, a_m0_rdata, a_m1_rdata); end
        n_tests++; if ({b_mem_req, b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_be} !== 9'b0) begin n_fail++; $display("FAIL reset_b got %b exp 0", {b_mem_req, b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_be}); end
        arstn = 1;
        idle_inputs();
        step();
    endtask

    task automatic test_read();
        do_reset();
        m0_req = 1; m0_we = 0; m0_be = 4'hF; m0_addr = 32'h10; mem_rdata_drv = 32'hDEAD_BEEF;
        step();
        n_tests++; if ({a_m0_gnt, a_m1_gnt, a_mem_req, a_mem_we} !== 4'b1010) begin n_fail++; $display("FAIL read_issue got %b exp 1010", {a_m0_gnt, a_m1_gnt, a_mem_req, a_mem_we}); end
        n_tests++; if (a_mem_addr !== 32'h10) begin n_fail++; $display("FAIL read_addr got %h exp 00000010", a_mem_addr); end
        step();
        n_tests++; if ({a_mem_req, a_m0_gnt, a_m0_rvalid} !== 3'b000) begin n_fail++; $display("FAIL read_wait got %b exp 000", {a_mem_req, a_m0_gnt, a_m0_rvalid}); end
        step();
        n_tests++; if ({a_m0_rvalid, a_m1_rvalid} !== 2'b10) begin n_fail++; $display("FAIL read_rvalid got %b exp 10", {a_m0_rvalid, a_m1_rvalid}); end
        n_tests++; if (a_m0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_rdata got %h exp deadbeef", a_m0_rdata); end
        n_tests++; if (a_m1_rdata !== 32'h0) begin n_fail++; $display("FAIL read_loser_rdata got %h exp 0", a_m1_rdata); end
        m0_req = 0;
        step();
        n_tests++; if ({a_m0_rvalid, a_m0_rdata} !== 33'd0) begin n_fail++; $display("FAIL read_after got rv=%b d=%h exp 0", a_m0_rvalid, a_m0_rdata); end
    endtask

    task automatic test_write();
        do_reset();
        m0_req = 1; m0_we = 1; m0_be = 4'b0100; m0_addr = 32'h20; m0_wdata = 32'h00AB_00AB;
        mem_rdata_drv = 32'h1234_5678;
        step();
        n_tests++; if ({a_mem_req, a_mem_we, a_mem_be} !== 6'b11_0100) begin n_fail++; $display("FAIL write_issue got %b exp 110100", {a_mem_req, a_mem_we, a_mem_be}); end
        n_tests++; if ({a_mem_addr, a_mem_wdata} !== {32'h20, 32'h00AB_00AB}) begin n_fail++; $display("FAIL write_fields addr=%h wdata=%h exp 00000020 00ab00ab", a_mem_addr, a_mem_wdata); end
        step();
        n_tests++; if ({a_mem_req, a_mem_we, a_mem_be} !== 6'b00_0100) begin n_fail++; $display("FAIL write_wait got %b exp 000100", {a_mem_req, a_mem_we, a_mem_be}); end
        step();
        n_tests++; if ({a_m0_rvalid, a_m0_rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL write_resp rv=%b d=%h exp 1 00000000", a_m0_rvalid, a_m0_rdata); end
        m0_req = 0; m0_we = 0;
        step();
    endtask

    task automatic test_back_to_back();
        logic e_g0, e_g1, e_v0, e_v1;
        logic [31:0] e_d0, e_d1;
        int ph, w;
        do_reset();
        use_model = 1;
        m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200;
        for (int s = 1; s <= 16; s++) begin
            step();
            ph = s % 4;
            w = ((s - 1) / 4) % 2;
            e_g0 = (ph == 1) && (w == 0);
            e_g1 = (ph == 1) && (w == 1);
            e_v0 = (ph == 3) && (w == 0);
            e_v1 = (ph == 3) && (w == 1);
            e_d0 = e_v0 ? 32'hA000_0100 : 32'h0;
            e_d1 = e_v1 ? 32'hA000_0200 : 32'h0;
            n_tests++; if ({a_m0_gnt, a_m1_gnt} !== {e_g0, e_g1}) begin n_fail++; $display("FAIL b2b_gnt step %0d got %b exp %b", s, {a_m0_gnt, a_m1_gnt}, {e_g0, e_g1}); end
            n_tests++; if ({a_m0_rvalid, a_m1_rvalid} !== {e_v0, e_v1}) begin n_fail++; $display("FAIL b2b_rvalid step %0d got %b exp %b", s, {a_m0_rvalid, a_m1_rvalid}, {e_v0, e_v1}); end
            n_tests++; if ({a_m0_rdata, a_m1_rdata} !== {e_d0, e_d1}) begin n_fail++; $display("FAIL b2b_rdata step %0d got %h %h exp %h %h", s, a_m0_rdata, a_m1_rdata, e_d0, e_d1); end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_late_req();
        do_reset();
        mem_rdata_drv = 32'h1111_2222;
        m0_req = 1; m0_addr = 32'h300;
        step();
        n_tests++; if ({a_m0_gnt, a_m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL late_first_gnt got %b exp 10", {a_m0_gnt, a_m1_gnt}); end
        step();
        m1_req = 1; m1_addr = 32'h400;
        step();
        n_tests++; if ({a_m0_rvalid, a_m1_gnt, a_m1_rvalid} !== 3'b100) begin n_fail++; $display("FAIL late_m0_resp got %b exp 100", {a_m0_rvalid, a_m1_gnt, a_m1_rvalid}); end
        step();
        n_tests++; if ({a_m0_gnt, a_m1_gnt, a_mem_req} !== 3'b000) begin n_fail++; $display("FAIL late_idle got %b exp 000", {a_m0_gnt, a_m1_gnt, a_mem_req}); end
        step();
        n_tests++; if ({a_m0_gnt, a_m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL late_second_gnt got %b exp 01", {a_m0_gnt, a_m1_gnt}); end
        n_tests++; if (a_mem_addr !== 32'h400) begin n_fail++; $display("FAIL late_addr got %h exp 00000400", a_mem_addr); end
        step();
        step();
        n_tests++; if ({a_m1_rvalid, a_m1_rdata, a_m0_rvalid} !== {1'b1, 32'h1111_2222, 1'b0}) begin n_fail++; $display("FAIL late_m1_resp rv=%b d=%h m0rv=%b exp 1 11112222 0", a_m1_rvalid, a_m1_rdata, a_m0_rvalid); end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_wait();
        logic saw_rv;
        do_reset();
        mem_rdata_drv = 32'h5555_5555;
        m0_req = 1; m0_addr = 32'h80;
        step();
        n_tests++; if (b_m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rstw_gnt got %b exp 1", b_m0_gnt); end
        step();
        arstn = 0;
        #1;
        n_tests++; if ({b_mem_req, b_m0_gnt, b_m0_rvalid, b_mem_addr, b_m0_rdata} !== 67'd0) begin n_fail++; $display("FAIL rstw_outputs req=%b gnt=%b rv=%b addr=%h d=%h exp 0", b_mem_req, b_m0_gnt, b_m0_rvalid, b_mem_addr, b_m0_rdata); end
        m1_req = 1; m1_addr = 32'h90;
        saw_rv = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            saw_rv = saw_rv | b_m0_rvalid | b_m1_rvalid | b_m0_gnt | b_m1_gnt;
        end
        arstn = 1;
        step();
        n_tests++; if ({b_m0_gnt, b_m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL rstw_first_gnt got %b exp 10", {b_m0_gnt, b_m1_gnt}); end
        n_tests++; if (saw_rv !== 1'b0) begin n_fail++; $display("FAIL rstw_no_rvalid got %b exp 0", saw_rv); end
        idle_inputs();
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_lat3_read();
        do_reset();
        mem_rdata_drv = 32'hBADB_AD00;
        m1_req = 1; m1_we = 0; m1_addr = 32'h40;
        step();
        n_tests++; if ({b_m1_gnt, b_m0_gnt, b_mem_req} !== 3'b101) begin n_fail++; $display("FAIL lat3_issue got %b exp 101", {b_m1_gnt, b_m0_gnt, b_mem_req}); end
        step();
        step();
        step();
        n_tests++; if ({b_m1_rvalid, b_mem_req} !== 2'b00) begin n_fail++; $display("FAIL lat3_wait got %b exp 00", {b_m1_rvalid, b_mem_req}); end
        mem_rdata_drv = 32'hCAFE_F00D;
        step();
        mem_rdata_drv = 32'hBADB_AD01;
        n_tests++; if ({b_m1_rvalid, b_m0_rvalid} !== 2'b10) begin n_fail++; $display("FAIL lat3_rvalid got %b exp 10", {b_m1_rvalid, b_m0_rvalid}); end
        n_tests++; if ({b_m1_rdata, b_m0_rdata} !== {32'hCAFE_F00D, 32'h0}) begin n_fail++; $display("FAIL lat3_rdata got %h %h exp cafef00d 00000000", b_m1_rdata, b_m0_rdata); end
        m1_req = 0;
        step();
        n_tests++; if (b_m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL lat3_after got %b exp 0", b_m1_rvalid); end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        idle_inputs();
        arstn = 0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_late_req();
        test_reset_wait();
        test_lat3_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
